// File: rtl/coef_matrix_bank.sv
// Double-buffered NCHAN x NCHAN coefficient matrix: shadow bank written by software, active bank swapped on sync.
// Optional readback mux is built only when COEF_READBACK_EN is defined.
module coef_matrix_bank #(
    parameter int          NCHAN  = 8,
    parameter int          CWIDTH = 32,
    parameter logic [31:0] IDENT  = 32'h7fff0000,
    parameter int          AW     = $clog2(NCHAN*NCHAN),
    parameter int          SCW    = 16
) (
    input  logic                       clk,
    input  logic                       aresetn,
    input  logic                       wstb,
    input  logic [AW-1:0]              waddr,
    input  logic [CWIDTH-1:0]          wdata,
    input  logic                       ident,
    input  logic                       commit,
    input  logic                       sync,
    input  logic [AW-1:0]              raddr,
    input  logic                       rsel,
    output logic [CWIDTH-1:0]          rdata,
    output logic [NCHAN*NCHAN*CWIDTH-1:0] coef,
    output logic                       pending,
    output logic [SCW-1:0]             swapcnt,
    output logic                       wrerr
);

    localparam int                NE      = NCHAN * NCHAN;
    localparam logic [AW:0]       NE_C    = (AW+1)'(NE);
    localparam logic [CWIDTH-1:0] IDENT_C = CWIDTH'(IDENT);
    localparam logic [CWIDTH-1:0] ZERO_C  = {CWIDTH{1'b0}};
    localparam logic [0:0]        S_IDLE  = 1'b0;
    localparam logic [0:0]        S_PEND  = 1'b1;

    function automatic logic [CWIDTH-1:0] ident_entry(input int idx);
        if ((idx / NCHAN) == (idx % NCHAN)) begin
            return IDENT_C;
        end else begin
            return ZERO_C;
        end
    endfunction

    logic [0:0]        state_q,   state_d;
    logic [CWIDTH-1:0] shadow_q [NE];
    logic [CWIDTH-1:0] shadow_d [NE];
    logic [CWIDTH-1:0] active_q [NE];
    logic [CWIDTH-1:0] active_d [NE];
    logic [SCW-1:0]    swapcnt_q, swapcnt_d;
    logic              wrerr_q,   wrerr_d;
    logic [CWIDTH-1:0] rdata_q,   rdata_d;

    logic pend_s, waddr_ok_s, wr_acc_s, id_acc_s, err_ev_s, swap_s;

    // Event decode: ident beats wstb silently; anything dropped while pending is an error.
    always_comb begin
        pend_s     = (state_q == S_PEND);
        waddr_ok_s = ({1'b0, waddr} < NE_C);
        wr_acc_s   = wstb & ~ident & ~pend_s & waddr_ok_s;
        id_acc_s   = ident & ~pend_s;
        err_ev_s   = (ident & pend_s) | (wstb & ~ident & (pend_s | ~waddr_ok_s));
        swap_s     = sync & (pend_s | commit);
    end

    // Bank next-state: active copies the post-write shadow so same-cycle writes bypass.
    always_comb begin
        for (int i = 0; i < NE; i++) begin
            if (id_acc_s) begin
                shadow_d[i] = ident_entry(i);
            end else if (wr_acc_s && (waddr == AW'(i))) begin
                shadow_d[i] = wdata;
            end else begin
                shadow_d[i] = shadow_q[i];
            end
            active_d[i] = swap_s ? shadow_d[i] : active_q[i];
        end
    end

    // Commit FSM, swap counter and sticky error flag.
    always_comb begin
        case (state_q)
            S_IDLE:  state_d = (commit & ~sync) ? S_PEND : S_IDLE;
            S_PEND:  state_d = sync ? S_IDLE : S_PEND;
            default: state_d = S_IDLE;
        endcase
        swapcnt_d = swap_s ? (swapcnt_q + SCW'(1)) : swapcnt_q;
        wrerr_d   = wrerr_q | err_ev_s;
    end

`ifdef COEF_READBACK_EN
    // Readback mux: one-hot OR over the selected bank; an out-of-range address matches nothing.
    always_comb begin
        rdata_d = ZERO_C;
        for (int i = 0; i < NE; i++) begin
            rdata_d = rdata_d | ((raddr == AW'(i)) ? (rsel ? active_q[i] : shadow_q[i]) : ZERO_C);
        end
    end
`else
    logic unused_rd_s;
    assign unused_rd_s = ^{raddr, rsel};

    // Readback disabled: data register held at zero.
    always_comb begin
        rdata_d = ZERO_C;
    end
`endif

    // State registers with synchronous active-low reset to identity.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q   <= S_IDLE;
            swapcnt_q <= {SCW{1'b0}};
            wrerr_q   <= 1'b0;
            rdata_q   <= ZERO_C;
            for (int i = 0; i < NE; i++) begin
                shadow_q[i] <= ident_entry(i);
                active_q[i] <= ident_entry(i);
            end
        end else begin
            state_q   <= state_d;
            swapcnt_q <= swapcnt_d;
            wrerr_q   <= wrerr_d;
            rdata_q   <= rdata_d;
            for (int i = 0; i < NE; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
        end
    end

    // Flatten the active bank onto the coefficient bus.
    always_comb begin
        coef = {(NE*CWIDTH){1'b0}};
        for (int i = 0; i < NE; i++) begin
            coef[i*CWIDTH +: CWIDTH] = active_q[i];
        end
    end

    assign pending = state_q;
    assign swapcnt = swapcnt_q;
    assign wrerr   = wrerr_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_coef_matrix_bank.sv
// Directed bench for coef_matrix_bank: main 8x8 instance plus a 3x3 instance for out-of-range writes.
module tb_coef_matrix_bank;

`ifdef COEF_READBACK_EN
    localparam bit RB_EN = 1'b1;
`else
    localparam bit RB_EN = 1'b0;
`endif
    localparam logic [31:0] ID = 32'h7fff0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         aresetn, wstb, ident, commit, sync, rsel;
    logic [5:0]   waddr, raddr;
    logic [31:0]  wdata, rdata;
    logic [2047:0] coef;
    logic         pending, wrerr;
    logic [15:0]  swapcnt;

    logic         wstb2, commit2, sync2, pending2, wrerr2;
    logic [3:0]   waddr2;
    logic [31:0]  rdata2;
    logic [287:0] coef2, exp2;
    logic [15:0]  swapcnt2;

    int checks = 0;
    int failures = 0;

    coef_matrix_bank dut (
        .clk(clk), .aresetn(aresetn), .wstb(wstb), .waddr(waddr), .wdata(wdata),
        .ident(ident), .commit(commit), .sync(sync), .raddr(raddr), .rsel(rsel),
        .rdata(rdata), .coef(coef), .pending(pending), .swapcnt(swapcnt), .wrerr(wrerr)
    );

    coef_matrix_bank #(.NCHAN(3)) dut2 (
        .clk(clk), .aresetn(aresetn), .wstb(wstb2), .waddr(waddr2), .wdata(wdata),
        .ident(1'b0), .commit(commit2), .sync(sync2), .raddr(4'd0), .rsel(1'b0),
        .rdata(rdata2), .coef(coef2), .pending(pending2), .swapcnt(swapcnt2), .wrerr(wrerr2)
    );

    function automatic logic [31:0] ent(input int i, input int j);
        return coef[(i*8+j)*32 +: 32];
    endfunction

    task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        aresetn = 1'b0; wstb = 1'b0; ident = 1'b0; commit = 1'b0; sync = 1'b0;
        rsel = 1'b0; waddr = 6'd0; raddr = 6'd0; wdata = 32'd0;
        wstb2 = 1'b0; commit2 = 1'b0; sync2 = 1'b0; waddr2 = 4'd0;
        tick(); tick();
        aresetn = 1'b1;
        tick();

        chk("rst_c00", ent(0, 0), ID);
        chk("rst_c01", ent(0, 1), 32'd0);
        chk("rst_c77", ent(7, 7), ID);
        chk("rst_swapcnt", swapcnt, 16'd0);
        chk("rst_pending", pending, 1'b0);
        chk("rst_wrerr", wrerr, 1'b0);
        chk("rst_rdata", rdata, 32'd0);

        // Write, commit, wait, sync
        wstb = 1'b1; waddr = 6'd1; wdata = 32'h12345678;
        tick();
        wstb = 1'b0; raddr = 6'd1; rsel = 1'b0; commit = 1'b1;
        tick();
        commit = 1'b0;
        chk("wr_readback_shadow", rdata, RB_EN ? 32'h12345678 : 32'd0);
        chk("commit_pending", pending, 1'b1);
        for (int k = 0; k < 5; k++) tick();
        chk("wait_pending", pending, 1'b1);
        chk("wait_c01_old", ent(0, 1), 32'd0);
        sync = 1'b1; rsel = 1'b1;
        tick();
        sync = 1'b0;
        chk("swap_c01_new", ent(0, 1), 32'h12345678);
        chk("swap_pending", pending, 1'b0);
        chk("swap_cnt1", swapcnt, 16'd1);
        tick();
        chk("rb_active", rdata, RB_EN ? 32'h12345678 : 32'd0);

        // Writes and ident dropped while pending
        commit = 1'b1;
        tick();
        commit = 1'b0;
        wstb = 1'b1; waddr = 6'd2; wdata = 32'hdeadbeef;
        tick();
        wstb = 1'b0; ident = 1'b1;
        tick();
        ident = 1'b0; rsel = 1'b0; raddr = 6'd2;
        chk("pend_wrerr", wrerr, 1'b1);
        tick();
        chk("pend_rb_addr2", rdata, 32'd0);
        raddr = 6'd1;
        tick();
        chk("pend_rb_addr1_kept", rdata, RB_EN ? 32'h12345678 : 32'd0);
        sync = 1'b1;
        tick();
        sync = 1'b0;
        chk("pend_c02", ent(0, 2), 32'd0);
        chk("pend_c01", ent(0, 1), 32'h12345678);
        chk("pend_c00", ent(0, 0), ID);
        chk("pend_swapcnt", swapcnt, 16'd2);

        // Fresh reset, then write+commit+sync in one cycle
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        chk("rst2_wrerr", wrerr, 1'b0);
        chk("rst2_c01", ent(0, 1), 32'd0);
        wstb = 1'b1; waddr = 6'd63; wdata = 32'h5; commit = 1'b1; sync = 1'b1;
        tick();
        wstb = 1'b0; commit = 1'b0; sync = 1'b0;
        chk("bypass_c77", ent(7, 7), 32'h5);
        chk("bypass_pending", pending, 1'b0);
        chk("bypass_swapcnt", swapcnt, 16'd1);
        chk("bypass_wrerr", wrerr, 1'b0);
        sync = 1'b1;
        tick();
        sync = 1'b0;
        chk("idle_sync_noswap", swapcnt, 16'd1);

        // 3x3 instance: valid write then out-of-range address
        wstb2 = 1'b1; waddr2 = 4'd5; wdata = 32'habc; commit2 = 1'b1; sync2 = 1'b1;
        tick();
        exp2 = '0;
        exp2[0*32 +: 32] = ID;
        exp2[4*32 +: 32] = ID;
        exp2[8*32 +: 32] = ID;
        exp2[5*32 +: 32] = 32'habc;
        chk("n3_valid_write", coef2, exp2);
        chk("n3_wrerr_clear", wrerr2, 1'b0);
        waddr2 = 4'd9; wdata = 32'hffff; commit2 = 1'b0; sync2 = 1'b0;
        tick();
        wstb2 = 1'b0; commit2 = 1'b1; sync2 = 1'b1;
        tick();
        commit2 = 1'b0; sync2 = 1'b0;
        chk("n3_oor_wrerr", wrerr2, 1'b1);
        chk("n3_oor_nochange", coef2, exp2);
        chk("n3_swapcnt", swapcnt2, 16'd2);

        // Reset in the middle of a pending commit
        wstb = 1'b1; waddr = 6'd0; wdata = 32'h1;
        tick();
        wstb = 1'b0; commit = 1'b1;
        tick();
        commit = 1'b0;
        chk("midpend_pending", pending, 1'b1);
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        chk("midrst_pending", pending, 1'b0);
        chk("midrst_c00", ent(0, 0), ID);
        chk("midrst_c77", ent(7, 7), ID);
        commit = 1'b1; sync = 1'b1;
        tick();
        commit = 1'b0; sync = 1'b0;
        chk("midrst_shadow_ident", ent(0, 0), ID);
        chk("midrst_swapcnt", swapcnt, 16'd1);

        // Swap counter wrap
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1; commit = 1'b1; sync = 1'b1;
        for (int k = 0; k < 65535; k++) tick();
        chk("wrap_max", swapcnt, 16'hffff);
        tick();
        commit = 1'b0; sync = 1'b0;
        chk("wrap_zero", swapcnt, 16'd0);
        chk("wrap_pending", pending, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
